// File: rtl/fb_scanout_pkg.sv
// Shared constants and types for the VGA framebuffer scanout path.
// 640x480 timing constants, RGB444 pixel type and swap FSM states.
package fb_scanout_pkg;

    localparam int DISPLAY_WIDTH  = 640;
    localparam int DISPLAY_HEIGHT = 480;
    localparam int H_FRONT        = 16;
    localparam int H_SYNC         = 96;
    localparam int H_BACK         = 48;
    localparam int V_FRONT        = 10;
    localparam int V_SYNC         = 2;
    localparam int V_BACK         = 33;
    localparam int H_TOTAL        = DISPLAY_WIDTH + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL        = DISPLAY_HEIGHT + V_FRONT + V_SYNC + V_BACK;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } pixel_t;

    typedef enum logic [1:0] {
        IDLE,
        PENDING,
        WAIT_DROP
    } swap_state_t;

    function automatic pixel_t bar_pixel(input logic [2:0] bar);
        pixel_t p;
        p.r = bar[2] ? 4'hF : 4'h0;
        p.g = bar[1] ? 4'hF : 4'h0;
        p.b = bar[0] ? 4'hF : 4'h0;
        return p;
    endfunction

endpackage

// File: rtl/fb_scanout_if.sv
// Framebuffer read bus plus the renderer bank-swap handshake.
// master = scanout side, slave = BRAM/renderer side.
interface fb_scanout_if #(
    parameter int ADDR_WIDTH  = 16,
    parameter int PIXEL_WIDTH = 12
);
    logic [ADDR_WIDTH-1:0]  fb_addr_out;
    logic [PIXEL_WIDTH-1:0] fb_data_in;
    logic                   swap_req_in;
    logic                   swap_ack_out;
    logic                   front_bank_out;

    modport master (
        output fb_addr_out,
        output swap_ack_out,
        output front_bank_out,
        input  fb_data_in,
        input  swap_req_in
    );

    modport slave (
        input  fb_addr_out,
        input  swap_ack_out,
        input  front_bank_out,
        output fb_data_in,
        output swap_req_in
    );
endinterface

// File: rtl/fb_scanout_sync_delay.sv
// Shift register that resets every stage to a fixed idle value.
// Aligns sync/blank (and optionally hcount) with the BRAM read path.
module fb_scanout_sync_delay #(
    parameter int               WIDTH   = 3,
    parameter int               DEPTH   = 3,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_pipe [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_pipe[i] <= RST_VAL;
            end
        end else begin
            r_pipe[0] <= i_d;
            for (int i = 1; i < DEPTH; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign o_q = r_pipe[DEPTH-1];

endmodule

// File: rtl/fb_scanout.sv
// Double-buffered, upscaled framebuffer scanout feeding the VGA DAC.
// Define FB_SCANOUT_TESTPAT_EN to add testpat_in (colour-bar pattern).
module fb_scanout
    import fb_scanout_pkg::*;
#(
    parameter int SCALE_SHIFT  = 2,
    parameter int BRAM_LATENCY = 2,
    parameter int PIXEL_WIDTH  = 12,
    parameter int ADDR_WIDTH   = 16
) (
    input  logic                   pixel_clk_in,
    input  logic                   rst_in,
    input  logic [10:0]            hcount_in,
    input  logic [9:0]             vcount_in,
    input  logic                   hsync_in,
    input  logic                   vsync_in,
    input  logic                   blank_in,
    output logic                   hsync_out,
    output logic                   vsync_out,
    output logic                   blank_out,
    output logic [PIXEL_WIDTH-1:0] rgb_out,
    fb_scanout_if.master           bus
`ifdef FB_SCANOUT_TESTPAT_EN
    ,
    input  logic                   testpat_in
`endif
);

    localparam int FB_W    = DISPLAY_WIDTH >> SCALE_SHIFT;
    localparam int FB_H    = DISPLAY_HEIGHT >> SCALE_SHIFT;
    localparam int FB_SIZE = FB_W * FB_H;
    localparam int LAT     = 1 + BRAM_LATENCY;
`ifdef FB_SCANOUT_TESTPAT_EN
    localparam int DW      = 6;
`else
    localparam int DW      = 3;
`endif
    localparam logic [DW-1:0] DLY_IDLE = DW'(3'b111) << (DW - 3);

    logic [ADDR_WIDTH-1:0]  r_addr;
    logic [ADDR_WIDTH-1:0]  r_row_base;
    logic [ADDR_WIDTH-1:0]  w_bank_base;
    logic [ADDR_WIDTH-1:0]  w_addr;
    logic                   w_in_range;
    logic                   w_line_end;
    logic                   w_swap_point;
    logic                   r_front;
    logic                   r_ack;
    logic                   w_swap;
    swap_state_t            r_state;
    swap_state_t            w_next;
    logic [DW-1:0]          w_dly_in;
    logic [DW-1:0]          w_dly;
    logic                   w_dly_blank;
    logic [PIXEL_WIDTH-1:0] w_pix;
    logic                   r_hsync;
    logic                   r_vsync;
    logic                   r_blank;
    logic [PIXEL_WIDTH-1:0] r_rgb;

    assign w_bank_base  = r_front ? ADDR_WIDTH'(FB_SIZE) : '0;
    assign w_in_range   = (hcount_in < 11'(DISPLAY_WIDTH)) &&
                          (vcount_in < 10'(DISPLAY_HEIGHT));
    assign w_line_end   = (hcount_in == 11'(DISPLAY_WIDTH));
    assign w_swap_point = (hcount_in == 11'd0) &&
                          (vcount_in == 10'(DISPLAY_HEIGHT));
    assign w_addr = w_in_range
                  ? w_bank_base + r_row_base + ADDR_WIDTH'(hcount_in >> SCALE_SHIFT)
                  : w_bank_base;

    always_ff @(posedge pixel_clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_addr <= '0;
        end else begin
            r_addr <= w_addr;
        end
    end

    // vblank lines keep row_base at 0 so each frame starts from row 0
    always_ff @(posedge pixel_clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_row_base <= '0;
        end else if (w_line_end) begin
            if (vcount_in >= 10'(DISPLAY_HEIGHT - 1)) begin
                r_row_base <= '0;
            end else if (&vcount_in[SCALE_SHIFT-1:0]) begin
                r_row_base <= r_row_base + ADDR_WIDTH'(FB_W);
            end
        end
    end

    always_ff @(posedge pixel_clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state <= IDLE;
            r_front <= 1'b0;
            r_ack   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_front <= r_front ^ w_swap;
            r_ack   <= w_swap;
        end
    end

    always_comb begin
        w_next = r_state;
        w_swap = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (bus.swap_req_in) begin
                    if (w_swap_point) begin
                        w_swap = 1'b1;
                        w_next = WAIT_DROP;
                    end else begin
                        w_next = PENDING;
                    end
                end
            end
            PENDING: begin
                if (!bus.swap_req_in) begin
                    w_next = IDLE;
                end else if (w_swap_point) begin
                    w_swap = 1'b1;
                    w_next = WAIT_DROP;
                end
            end
            WAIT_DROP: begin
                if (!bus.swap_req_in) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

`ifdef FB_SCANOUT_TESTPAT_EN
    assign w_dly_in = {hsync_in, vsync_in, blank_in, hcount_in[9:7]};
`else
    assign w_dly_in = {hsync_in, vsync_in, blank_in};
`endif

    fb_scanout_sync_delay #(
        .WIDTH   (DW),
        .DEPTH   (LAT),
        .RST_VAL (DLY_IDLE)
    ) u_sync_delay (
        .clk (pixel_clk_in),
        .rst (rst_in),
        .i_d (w_dly_in),
        .o_q (w_dly)
    );

    assign w_dly_blank = w_dly[DW-3];

`ifdef FB_SCANOUT_TESTPAT_EN
    assign w_pix = testpat_in ? PIXEL_WIDTH'(bar_pixel(w_dly[2:0]))
                              : bus.fb_data_in;
`else
    assign w_pix = bus.fb_data_in;
`endif

    // output stage lines up with BRAM data for the pixel sampled LAT cycles ago
    always_ff @(posedge pixel_clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_hsync <= 1'b1;
            r_vsync <= 1'b1;
            r_blank <= 1'b1;
            r_rgb   <= '0;
        end else begin
            r_hsync <= w_dly[DW-1];
            r_vsync <= w_dly[DW-2];
            r_blank <= w_dly_blank;
            r_rgb   <= w_dly_blank ? '0 : w_pix;
        end
    end

    assign bus.fb_addr_out    = r_addr;
    assign bus.swap_ack_out   = r_ack;
    assign bus.front_bank_out = r_front;
    assign hsync_out          = r_hsync;
    assign vsync_out          = r_vsync;
    assign blank_out          = r_blank;
    assign rgb_out            = r_rgb;

endmodule

// File: tb/tb_fb_scanout.sv
// Directed-vector bench for fb_scanout with a 2-cycle BRAM model
// that returns the low address bits as pixel data.
module tb_fb_scanout;
    import fb_scanout_pkg::*;

    localparam int HS0 = DISPLAY_WIDTH + H_FRONT;
    localparam int VS0 = DISPLAY_HEIGHT + V_FRONT;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] hcount = '0;
    logic [9:0]  vcount = '0;
    logic        hsync = 1'b1;
    logic        vsync = 1'b1;
    logic        blank = 1'b1;
    logic        req = 1'b0;
    logic        testpat = 1'b0;
    logic        hsync_out, vsync_out, blank_out;
    logic [11:0] rgb_out;
    logic [15:0] r1 = '0;
    logic [15:0] r2 = '0;

    int          n_vec = 0;
    int          n_miss = 0;
    int          n_app = 0;
    int          acks = 0;
    int          exp_bank = 0;
    bit          tp = 1'b0;
    logic [14:0] ring [4];

    fb_scanout_if bus ();

    fb_scanout dut (
        .pixel_clk_in (clk),
        .rst_in       (rst),
        .hcount_in    (hcount),
        .vcount_in    (vcount),
        .hsync_in     (hsync),
        .vsync_in     (vsync),
        .blank_in     (blank),
        .hsync_out    (hsync_out),
        .vsync_out    (vsync_out),
        .blank_out    (blank_out),
        .rgb_out      (rgb_out),
        .bus          (bus)
`ifdef FB_SCANOUT_TESTPAT_EN
        ,
        .testpat_in   (testpat)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        r1 <= bus.fb_addr_out;
        r2 <= r1;
    end

    assign bus.fb_data_in  = r2[11:0];
    assign bus.swap_req_in = req;

    function automatic logic [11:0] model_pix(input int h, input int v);
        int          a;
        logic [10:0] hh;
        a  = exp_bank * 19200;
        hh = 11'(h);
        if (h < DISPLAY_WIDTH && v < DISPLAY_HEIGHT) a = a + (v / 4) * 160 + h / 4;
        if (tp) return {{4{hh[9]}}, {4{hh[8]}}, {4{hh[7]}}};
        return a[11:0];
    endfunction

    task automatic apply(input int h, input int v);
        hcount = 11'(h);
        vcount = 10'(v);
        blank  = (h >= DISPLAY_WIDTH) || (v >= DISPLAY_HEIGHT);
        hsync  = !((h >= HS0) && (h < HS0 + H_SYNC));
        vsync  = !((v >= VS0) && (v < VS0 + V_SYNC));
        ring[n_app[1:0]] = {hsync, vsync, blank, blank ? 12'h000 : model_pix(h, v)};
        n_app++;
        @(posedge clk);
        #1;
        if (bus.swap_ack_out) acks++;
    endtask

    task automatic run_lines(input int a, input int b);
        for (int v = a; v <= b; v++) apply(DISPLAY_WIDTH, v);
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if ({hsync_out, vsync_out, blank_out} !== 3'b111) begin
            n_miss++;
            $display("FAIL rst_sync: got %b want 111", {hsync_out, vsync_out, blank_out});
        end
        n_vec++;
        if (rgb_out !== 12'h000) begin
            n_miss++;
            $display("FAIL rst_rgb: got %h want 000", rgb_out);
        end
        n_vec++;
        if (bus.fb_addr_out !== 16'd0) begin
            n_miss++;
            $display("FAIL rst_addr: got %0d want 0", bus.fb_addr_out);
        end
        n_vec++;
        if ({bus.swap_ack_out, bus.front_bank_out} !== 2'b00) begin
            n_miss++;
            $display("FAIL rst_swap: got %b want 00", {bus.swap_ack_out, bus.front_bank_out});
        end
        rst = 1'b0;
    endtask

    task automatic test_addr;
        run_lines(0, 8);
        apply(5, 9);
        n_vec++;
        if (bus.fb_addr_out !== 16'd321) begin
            n_miss++;
            $display("FAIL addr_5_9: got %0d want 321", bus.fb_addr_out);
        end
        apply(639, 9);
        n_vec++;
        if (bus.fb_addr_out !== 16'd479) begin
            n_miss++;
            $display("FAIL addr_639_9: got %0d want 479", bus.fb_addr_out);
        end
        apply(H_TOTAL - 1, 9);
        n_vec++;
        if (bus.fb_addr_out !== 16'd0) begin
            n_miss++;
            $display("FAIL addr_hblank: got %0d want 0", bus.fb_addr_out);
        end
        apply(5, 480);
        n_vec++;
        if (bus.fb_addr_out !== 16'd0) begin
            n_miss++;
            $display("FAIL addr_vblank: got %0d want 0", bus.fb_addr_out);
        end
    endtask

    task automatic test_pipeline;
        for (int h = 630; h <= 660; h++) begin
            apply(h, 10);
            if (h >= 633) begin
                n_vec++;
                if ({hsync_out, vsync_out, blank_out, rgb_out} !== ring[n_app[1:0]]) begin
                    n_miss++;
                    $display("FAIL pipe_h%0d: got %h want %h", h - 3,
                             {hsync_out, vsync_out, blank_out, rgb_out}, ring[n_app[1:0]]);
                end
            end
        end
    endtask

    task automatic test_swap;
        req = 1'b1;
        apply(0, 100);
        n_vec++;
        if ({bus.swap_ack_out, bus.front_bank_out} !== 2'b00) begin
            n_miss++;
            $display("FAIL swap_pend: got %b want 00", {bus.swap_ack_out, bus.front_bank_out});
        end
        acks = 0;
        run_lines(101, 479);
        n_vec++;
        if (acks !== 0) begin
            n_miss++;
            $display("FAIL swap_early: got %0d acks want 0", acks);
        end
        apply(0, 480);
        n_vec++;
        if ({bus.swap_ack_out, bus.front_bank_out} !== 2'b11) begin
            n_miss++;
            $display("FAIL swap_do: got %b want 11", {bus.swap_ack_out, bus.front_bank_out});
        end
        exp_bank = 1;
        acks = 0;
        apply(1, 480);
        n_vec++;
        if ({bus.swap_ack_out, bus.front_bank_out} !== 2'b01) begin
            n_miss++;
            $display("FAIL swap_pulse: got %b want 01", {bus.swap_ack_out, bus.front_bank_out});
        end
        run_lines(480, V_TOTAL - 1);
        run_lines(0, 8);
        apply(5, 9);
        n_vec++;
        if (bus.fb_addr_out !== 16'd19521) begin
            n_miss++;
            $display("FAIL addr_bank1: got %0d want 19521", bus.fb_addr_out);
        end
        apply(6, 9);
        apply(7, 9);
        apply(8, 9);
        n_vec++;
        if ({hsync_out, vsync_out, blank_out, rgb_out} !== ring[n_app[1:0]]) begin
            n_miss++;
            $display("FAIL pipe_bank1: got %h want %h",
                     {hsync_out, vsync_out, blank_out, rgb_out}, ring[n_app[1:0]]);
        end
        run_lines(9, 479);
        apply(0, 480);
        n_vec++;
        if ({bus.swap_ack_out, bus.front_bank_out} !== 2'b01 || acks !== 0) begin
            n_miss++;
            $display("FAIL swap_held: got %b acks %0d want 01 acks 0",
                     {bus.swap_ack_out, bus.front_bank_out}, acks);
        end
        req = 1'b0;
        apply(1, 480);
    endtask

    task automatic test_swap_edge;
        req = 1'b1;
        apply(0, 480);
        n_vec++;
        if ({bus.swap_ack_out, bus.front_bank_out} !== 2'b10) begin
            n_miss++;
            $display("FAIL swap_rise: got %b want 10", {bus.swap_ack_out, bus.front_bank_out});
        end
        exp_bank = 0;
        req = 1'b0;
        apply(1, 480);
        req = 1'b1;
        apply(5, 481);
        n_vec++;
        if ({bus.swap_ack_out, bus.front_bank_out} !== 2'b00) begin
            n_miss++;
            $display("FAIL swap_pend2: got %b want 00", {bus.swap_ack_out, bus.front_bank_out});
        end
        req = 1'b0;
        apply(6, 481);
        apply(0, 480);
        n_vec++;
        if ({bus.swap_ack_out, bus.front_bank_out} !== 2'b00) begin
            n_miss++;
            $display("FAIL swap_drop: got %b want 00", {bus.swap_ack_out, bus.front_bank_out});
        end
        req = 1'b1;
        apply(3, 480);
        n_vec++;
        if ({bus.swap_ack_out, bus.front_bank_out} !== 2'b00) begin
            n_miss++;
            $display("FAIL swap_late: got %b want 00", {bus.swap_ack_out, bus.front_bank_out});
        end
        apply(0, 480);
        n_vec++;
        if ({bus.swap_ack_out, bus.front_bank_out} !== 2'b11) begin
            n_miss++;
            $display("FAIL swap_next: got %b want 11", {bus.swap_ack_out, bus.front_bank_out});
        end
        exp_bank = 1;
        req = 1'b0;
        apply(1, 480);
    endtask

    task automatic test_reset_mid;
        repeat (4) apply(100, 20);
        n_vec++;
        if (blank_out !== 1'b0) begin
            n_miss++;
            $display("FAIL mid_active: got blank %b want 0", blank_out);
        end
        #3;
        rst = 1'b1;
        #1;
        n_vec++;
        if ({hsync_out, vsync_out, blank_out, rgb_out} !== 15'h7000) begin
            n_miss++;
            $display("FAIL mid_out: got %h want 7000", {hsync_out, vsync_out, blank_out, rgb_out});
        end
        n_vec++;
        if ({bus.fb_addr_out, bus.front_bank_out, bus.swap_ack_out} !== 18'd0) begin
            n_miss++;
            $display("FAIL mid_addr: got addr %0d bank %b ack %b want 0 0 0",
                     bus.fb_addr_out, bus.front_bank_out, bus.swap_ack_out);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_bank = 0;
    endtask

`ifdef FB_SCANOUT_TESTPAT_EN
    task automatic test_testpat;
        int hl [10];
        hl = '{0, 64, 127, 128, 130, 300, 520, 639, 640, 896};
        tp = 1'b1;
        testpat = 1'b1;
        for (int i = 0; i < 10; i++) begin
            apply(hl[i], 20);
            if (i >= 3) begin
                n_vec++;
                if ({hsync_out, vsync_out, blank_out, rgb_out} !== ring[n_app[1:0]]) begin
                    n_miss++;
                    $display("FAIL tp_h%0d: got %h want %h", hl[i-3],
                             {hsync_out, vsync_out, blank_out, rgb_out}, ring[n_app[1:0]]);
                end
            end
        end
        tp = 1'b0;
        testpat = 1'b0;
    endtask
`endif

    initial begin
        test_reset;
        test_addr;
        test_pipeline;
        test_swap;
        test_swap_edge;
        test_reset_mid;
`ifdef FB_SCANOUT_TESTPAT_EN
        test_testpat;
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
